// File: rtl/apb_transfer_controller.sv
// ----------------------------------------------------------------------------
// apb_transfer_controller
//
// Bridge-side sequencer between an AHB slave port and an APB bus. A transfer
// that is accepted from the AHB address phase becomes an APB SETUP phase and
// then an ACCESS phase. Writes first take one WWAIT cycle so that the AHB data
// phase can deliver Hwdata. Hreadyout holds the AHB master off until the APB
// slave completes. A slave that keeps Pready low for too long is abandoned,
// and the master gets a two-cycle ERROR response.
//
// Ports
//   Hclk, Hreset       clock, asynchronous active-high reset
//   valid              address phase carries a transfer for this bridge
//   Haddr, Hwrite      address-phase address / direction
//   tempselx           decoded one-hot slave select for Haddr
//   Hwdata             AHB write data (data phase)
//   Pready, Prdata     APB slave ready / read data
//   Pwrite, Penable,
//   Pselx, Paddr,
//   Pwdata             APB master outputs
//   Hreadyout, Hresp   AHB ready / response (1 = ERROR)
//   Hrdata             AHB read data, passed through from Prdata
// ----------------------------------------------------------------------------
module apb_transfer_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [NSLV-1:0]   tempselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic              Pready,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic [NSLV-1:0]   Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic              Hresp,
    output logic [DATA_W-1:0] Hrdata
);

    typedef enum logic [2:0] {
        IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2
    } state_t;

    // The counter is kept at least 1 bit wide so that TIMEOUT=0 still elaborates.
    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

    state_t          state, state_nxt;
    logic [NSLV-1:0] sel_reg;
    logic [CW-1:0]   wait_cnt;
    logic            accept;
    logic            sel_ok;
    logic            timeout_hit;
    logic            psel_on;

    // A select is legal only if exactly one bit is set.
    assign sel_ok      = (tempselx != '0) && ((tempselx & (tempselx - 1'b1)) == '0);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        Hreadyout = 1'b1;
        Hresp     = 1'b0;
        Penable   = 1'b0;
        psel_on   = 1'b0;
        case (state)
            IDLE: begin
                accept = valid;
            end
            WWAIT: begin
                Hreadyout = 1'b0;
                state_nxt = SETUP;
            end
            SETUP: begin
                Hreadyout = 1'b0;
                psel_on   = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel_on = 1'b1;
                Penable = 1'b1;
                if (Pready) begin
                    // Completion also opens the next address phase, which gives
                    // back-to-back transfers without an IDLE cycle.
                    Hreadyout = 1'b1;
                    accept    = valid;
                    state_nxt = IDLE;
                end else begin
                    Hreadyout = 1'b0;
                    if (timeout_hit)
                        state_nxt = ERR1;
                end
            end
            ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 1'b1;
                state_nxt = ERR2;
            end
            ERR2: begin
                // The master sees ERROR with Hreadyout high here, so the address
                // phase in this cycle is dropped.
                Hresp     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept)
            state_nxt = !sel_ok ? ERR1 : (Hwrite ? WWAIT : SETUP);
    end

    assign Pselx  = psel_on ? sel_reg : '0;
    assign Hrdata = Prdata;

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state    <= IDLE;
            sel_reg  <= '0;
            Paddr    <= '0;
            Pwrite   <= 1'b0;
            Pwdata   <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                Paddr   <= Haddr;
                Pwrite  <= Hwrite;
                sel_reg <= tempselx;
            end
            if (state == WWAIT)
                Pwdata <= Hwdata;
            if (state == SETUP)
                wait_cnt <= '0;
            else if (state == ACCESS && !Pready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule
